// File: rtl/alu_mdu.sv
// alu_mdu: single-issue integer ALU with an iterative multiply/divide unit.
// Base ops complete in one cycle; MUL*/DIV* run one bit per cycle for XLEN cycles.
// Define ALU_MDU_DIV_EN to build the iterative divider; without it DIV/DIVU/REM/REMU
// behave as undefined ops (result 0, one-cycle latency).
module alu_mdu #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [4:0]      op_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [SHW:0] CntInit = (SHW + 1)'(XLEN);
  localparam logic [SHW:0] CntLast = (SHW + 1)'(1);

  state_e            r_state;
  logic [SHW:0]      r_cnt;
  logic [XLEN-1:0]   r_result;
  logic              r_out_valid;
  // r_hi/r_lo: product accumulator/multiplier, or partial remainder/quotient
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_mcand;
  logic              r_is_div;
  logic [1:0]        r_sub;
  logic              r_neg;
  logic              r_neg_r;
  logic              r_bzero;
  logic [XLEN-1:0]   r_a;

  logic [SHW-1:0]    w_shamt;
  logic [XLEN-1:0]   w_base;
  logic              w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic              w_is_mul, w_is_div;
  logic [XLEN-1:0]   w_mcand, w_mplier;
  logic              w_mul_neg;
  logic [XLEN-1:0]   w_dvd, w_dvs;
  logic              w_neg_q, w_neg_r;
  logic [XLEN:0]     w_sum;
  logic [XLEN-1:0]   w_mul_hi, w_mul_lo;
  logic [XLEN-1:0]   w_div_hi, w_div_lo;
  logic [XLEN-1:0]   w_nx_hi, w_nx_lo;
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0]   w_mul_res, w_quo, w_rem, w_div_res, w_fin;

  assign w_shamt = b_i[SHW-1:0];
  assign w_a_neg = a_i[XLEN-1];
  assign w_b_neg = b_i[XLEN-1];
  assign w_a_mag = w_a_neg ? -a_i : a_i;
  assign w_b_mag = w_b_neg ? -b_i : b_i;

  // Single-cycle base operations; unlisted codes yield zero
  always_comb begin
    w_base = '0;
    case (op_i)
      5'b00000: w_base = a_i + b_i;
      5'b01000: w_base = a_i - b_i;
      5'b00010: w_base = XLEN'($signed(a_i) < $signed(b_i));
      5'b00011: w_base = XLEN'(a_i < b_i);
      5'b00111: w_base = a_i & b_i;
      5'b00110: w_base = a_i | b_i;
      5'b00100: w_base = a_i ^ b_i;
      5'b00001: w_base = a_i << w_shamt;
      5'b00101: w_base = a_i >> w_shamt;
      5'b01101: w_base = $signed(a_i) >>> w_shamt;
      default:  w_base = '0;
    endcase
  end

  // Operand preparation at accept: signed ops run on magnitudes, sign fixed at the end
  always_comb begin
    w_is_mul  = (op_i[4:2] == 3'b100);
    // MULH (01) and MULHSU (10) treat a as signed; only MULH treats b as signed
    w_mcand   = ((op_i[1:0] == 2'b01 || op_i[1:0] == 2'b10) && w_a_neg) ? w_a_mag : a_i;
    w_mplier  = ((op_i[1:0] == 2'b01) && w_b_neg) ? w_b_mag : b_i;
    w_mul_neg = ((op_i[1:0] == 2'b01 || op_i[1:0] == 2'b10) && w_a_neg) ^
                ((op_i[1:0] == 2'b01) && w_b_neg);
`ifdef ALU_MDU_DIV_EN
    w_is_div  = (op_i[4:2] == 3'b101);
    // DIV/REM have op_i[0]=0 and are signed
    w_dvd     = (!op_i[0] && w_a_neg) ? w_a_mag : a_i;
    w_dvs     = (!op_i[0] && w_b_neg) ? w_b_mag : b_i;
    w_neg_q   = !op_i[0] && (w_a_neg ^ w_b_neg);
    w_neg_r   = !op_i[0] && w_a_neg;
`else
    w_is_div  = 1'b0;
    w_dvd     = '0;
    w_dvs     = '0;
    w_neg_q   = 1'b0;
    w_neg_r   = 1'b0;
`endif
  end

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
    w_mul_hi = w_sum[XLEN:1];
    w_mul_lo = {w_sum[0], r_lo[XLEN-1:1]};
`ifdef ALU_MDU_DIV_EN
    begin : g_div_step
      logic [XLEN:0] w_trial;
      w_trial = {r_hi, r_lo[XLEN-1]} - {1'b0, r_mcand};
      if (!w_trial[XLEN]) begin
        w_div_hi = w_trial[XLEN-1:0];
        w_div_lo = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_div_hi = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
        w_div_lo = {r_lo[XLEN-2:0], 1'b0};
      end
    end
`else
    w_div_hi = r_hi;
    w_div_lo = r_lo;
`endif
    w_nx_hi = r_is_div ? w_div_hi : w_mul_hi;
    w_nx_lo = r_is_div ? w_div_lo : w_mul_lo;
  end

  // Final sign correction and special cases, applied on the last iteration
  always_comb begin
    w_prod    = {w_nx_hi, w_nx_lo};
    w_prod_s  = r_neg ? -w_prod : w_prod;
    w_mul_res = (r_sub == 2'b00) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];
    w_quo     = r_bzero ? '1  : (r_neg ? -w_nx_lo : w_nx_lo);
    w_rem     = r_bzero ? r_a : (r_neg_r ? -w_nx_hi : w_nx_hi);
    w_div_res = r_sub[1] ? w_rem : w_quo;
    w_fin     = r_is_div ? w_div_res : w_mul_res;
  end

  // Control FSM with registered result and handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_mcand     <= '0;
      r_is_div    <= 1'b0;
      r_sub       <= '0;
      r_neg       <= 1'b0;
      r_neg_r     <= 1'b0;
      r_bzero     <= 1'b0;
      r_a         <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid_i) begin
            if (w_is_mul || w_is_div) begin
              r_hi     <= '0;
              r_lo     <= w_is_div ? w_dvd : w_mplier;
              r_mcand  <= w_is_div ? w_dvs : w_mcand;
              r_neg    <= w_is_div ? w_neg_q : w_mul_neg;
              r_neg_r  <= w_neg_r;
              r_bzero  <= w_is_div && (b_i == '0);
              r_a      <= a_i;
              r_is_div <= w_is_div;
              r_sub    <= op_i[1:0];
              r_cnt    <= CntInit;
              r_state  <= StBusy;
            end else begin
              r_result    <= w_base;
              r_out_valid <= 1'b1;
              r_state     <= StDone;
            end
          end
        end
        StBusy: begin
          r_hi  <= w_nx_hi;
          r_lo  <= w_nx_lo;
          r_cnt <= r_cnt - CntLast;
          if (r_cnt == CntLast) begin
            r_result    <= w_fin;
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready_o  = (r_state == StIdle);
  assign out_valid_o = r_out_valid;
  assign result_o    = r_result;

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed and random checks of alu_mdu (XLEN=32) against an arithmetic model.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic [4:0]  op_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] result_o;

  int n_vec = 0;
  int n_err = 0;

  alu_mdu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .op_i        (op_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected summary");
    $fatal(1, "watchdog expired");
  end

  localparam logic [4:0] OpAdd = 5'b00000, OpSub = 5'b01000, OpSlt = 5'b00010;
  localparam logic [4:0] OpSltu = 5'b00011, OpAnd = 5'b00111, OpOr = 5'b00110;
  localparam logic [4:0] OpXor = 5'b00100, OpSll = 5'b00001, OpSrl = 5'b00101;
  localparam logic [4:0] OpSra = 5'b01101, OpMul = 5'b10000, OpMulh = 5'b10001;
  localparam logic [4:0] OpMulhsu = 5'b10010, OpMulhu = 5'b10011, OpDiv = 5'b10100;
  localparam logic [4:0] OpDivu = 5'b10101, OpRem = 5'b10110, OpRemu = 5'b10111;

  // Reference result from plain integer arithmetic
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, b);
    int              sa;
    int              sb;
    longint          p;
    longint unsigned pu;
    logic [63:0]     pv;
    sa = a;
    sb = b;
    case (op)
      OpAdd:    return a + b;
      OpSub:    return a - b;
      OpSlt:    return (sa < sb) ? 32'd1 : 32'd0;
      OpSltu:   return (a < b) ? 32'd1 : 32'd0;
      OpAnd:    return a & b;
      OpOr:     return a | b;
      OpXor:    return a ^ b;
      OpSll:    return a << b[4:0];
      OpSrl:    return a >> b[4:0];
      OpSra:    return sa >>> b[4:0];
      OpMul:    return a * b;
      OpMulh: begin
        p = longint'(sa) * longint'(sb);
        pv = p;
        return pv[63:32];
      end
      OpMulhsu: begin
        p = longint'(sa) * longint'({32'h0, b});
        pv = p;
        return pv[63:32];
      end
      OpMulhu: begin
        pu = {32'h0, a} * {32'h0, b};
        pv = pu;
        return pv[63:32];
      end
`ifdef ALU_MDU_DIV_EN
      OpDiv: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return sa / sb;
      end
      OpDivu:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OpRem: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sb;
      end
      OpRemu:   return (b == 0) ? a : a % b;
`endif
      default:  return 32'h0;
    endcase
  endfunction

  function automatic int model_lat(input logic [4:0] op);
    if (op[4:2] == 3'b100) return 33;
`ifdef ALU_MDU_DIV_EN
    if (op[4:2] == 3'b101) return 33;
`endif
    return 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, check latency/result, hold the result for `hold` cycles, then release
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit noise);
    logic [31:0] e_res;
    int          e_lat;
    int          cyc;
    e_res = model(op, a, b);
    e_lat = model_lat(op);
    @(negedge clk);
    chk("ready_idle", 64'(in_ready_o), 64'd1);
    in_valid_i = 1'b1;
    op_i = op;
    a_i = a;
    b_i = b;
    @(negedge clk);
    cyc = 1;
    chk("ready_low_c1", 64'(in_ready_o), 64'd0);
    // Junk on the inputs while the op is in flight must not matter
    in_valid_i = noise;
    a_i = $urandom;
    b_i = $urandom;
    op_i = 5'($urandom);
    while (!out_valid_o && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("latency op=%b", op), 64'(cyc), 64'(e_lat));
    chk($sformatf("result op=%b a=%h b=%h", op, a, b), 64'(result_o), 64'(e_res));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid_o), 64'd1);
      chk("hold_result", 64'(result_o), 64'(e_res));
      chk("hold_ready", 64'(in_ready_o), 64'd0);
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    chk("released_valid", 64'(out_valid_o), 64'd0);
    chk("released_ready", 64'(in_ready_o), 64'd1);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'(int'($urandom_range(0, 15)));
      default: return $urandom;
    endcase
  endfunction

  logic [4:0] ops[20] = '{OpAdd, OpSub, OpSlt, OpSltu, OpAnd, OpOr, OpXor, OpSll, OpSrl,
                          OpSra, OpMul, OpMulh, OpMulhsu, OpMulhu, OpDiv, OpDivu, OpRem,
                          OpRemu, 5'b11000, 5'b01001};

  initial begin
    bit stray;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_result", 64'(result_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(in_ready_o), 64'd1);

    // Directed corner cases
    run_op(OpAdd, 32'hFFFF_FFFF, 32'h1, 0, 1'b0);
    run_op(OpSra, 32'h8000_0000, 32'h24, 0, 1'b0);
    run_op(OpSlt, 32'hFFFF_FFFF, 32'h1, 0, 1'b0);
    run_op(OpSltu, 32'hFFFF_FFFF, 32'h1, 0, 1'b0);
    run_op(OpMulh, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1);
    run_op(OpMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(OpDivu, 32'h1234_5678, 32'h0, 0, 1'b0);
    run_op(OpRemu, 32'h1234_5678, 32'h0, 0, 1'b0);
    run_op(OpRem, 32'hFFFF_FFF9, 32'h2, 0, 1'b0);
    run_op(5'b11111, 32'h5, 32'h6, 0, 1'b0);
    // Stall in DONE for five cycles, for a base op and a multi-cycle op
    run_op(OpXor, 32'hA5A5_0F0F, 32'h0FF0_FFFF, 5, 1'b1);
    run_op(OpMul, 32'hDEAD_BEEF, 32'h1357_9BDF, 5, 1'b1);

    // Randomized ops
    for (int n = 0; n < 60; n++) begin
      run_op(ops[$urandom_range(0, 19)], pick_operand(), pick_operand(),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset while BUSY aborts the op
    @(negedge clk);
    in_valid_i = 1'b1;
    op_i = OpMulhu;
    a_i = $urandom;
    b_i = $urandom;
    @(negedge clk);
    in_valid_i = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_before_rst", 64'(in_ready_o), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_valid", 64'(out_valid_o), 64'd0);
    chk("abort_result", 64'(result_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", 64'(in_ready_o), 64'd1);
    chk("abort_valid_after", 64'(out_valid_o), 64'd0);
    stray = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid_o !== 1'b0) stray = 1'b1;
    end
    chk("abort_no_result", 64'(stray), 64'd0);
    run_op(OpMulh, 32'h8000_0000, 32'h8000_0000, 1, 1'b0);
    run_op(OpSub, 32'h0, 32'h1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
